pixel_scan_gen: RTL and testbench
=================================

// Module: pixel_scan_gen
// PURPOSE
//   Raster-scan pixel source for pixel_map: issues every (x,y) of a frame in row-major order
//   under a valid/full_queue handshake. Latches zoom/offset once per frame so all pixels of
//   a frame use the same view. Counts pixels still in flight and signals frame completion
//   once every issued pixel is retired by the engines.
// PARAMETERS
//   PIXEL_DATA_WIDTH   10   width of pixel_x/pixel_y
//   ENGINE_DATA_WIDTH  25   width of x/y offset (signed fixed point, passed through)
//   SCREEN_WIDTH       640  pixels per line
//   SCREEN_HEIGHT      480  lines per frame
//   CNT_WIDTH          19   width of outstanding-pixel counter (>= clog2(W*H+1))
// PORTS
//   clk            in   1    clock
//   reset          in   1    asynchronous, active-high reset
//   en             in   1    scan enable; 0 pauses issue
//   restart        in   1    1-cycle pulse: abandon scan, relatch view, restart at (0,0)
//   full_queue     in   1    downstream cannot accept; holds current pixel
//   pixel_done     in   1    1-cycle pulse: one issued pixel retired by an engine
//   zoom           in   3    view zoom (sampled at frame start)
//   x_offset       in   ENGINE_DATA_WIDTH  signed real offset (sampled at frame start)
//   y_offset       in   ENGINE_DATA_WIDTH  signed imag offset (sampled at frame start)
//   pixel_x        out  PIXEL_DATA_WIDTH   current pixel column
//   pixel_y        out  PIXEL_DATA_WIDTH   current pixel row
//   pix_valid      out  1    pixel_x/pixel_y valid for transfer
//   zoom_frame     out  3    latched zoom for current frame
//   x_off_frame    out  ENGINE_DATA_WIDTH  latched x_offset
//   y_off_frame    out  ENGINE_DATA_WIDTH  latched y_offset
//   frame_start    out  1    1-cycle pulse when a frame's view is latched
//   frame_done     out  1    level: all pixels issued and retired
// BEHAVIOUR
//   - Reset (async): state IDLE; all outputs 0; outstanding count 0.
//   - Transfer: posedge with pix_valid=1 and full_queue=0. Pixel held stable while full_queue=1.
//   - FSM IDLE: en=1 -> latch zoom/offsets, frame_start=1 for one cycle, pixel=(0,0),
//     pix_valid=1 next cycle, go SCAN. First pixel is presented 1 cycle after en rises.
//   - SCAN: on transfer x+1; at x=SCREEN_WIDTH-1 x wraps to 0 and y+1. Transfer of
//     (W-1,H-1) -> pix_valid=0, go DRAIN. en=0 -> pix_valid=0 next cycle, position held;
//     en=1 resumes at same pixel (no skip, no repeat).
//   - DRAIN: pix_valid=0; when outstanding==0 -> DONE, frame_done=1 next cycle.
//   - DONE: frame_done held 1, pix_valid=0. restart with en=1 -> as IDLE entry, frame_done=0.
//   - restart (en=1) in SCAN or DRAIN: next cycle pixel=(0,0), view relatched, frame_start
//     pulse, frame_done=0, state SCAN. restart wins over a same-cycle transfer; that
//     transferred pixel still counts as outstanding. Outstanding is NOT cleared (stale
//     pixels still retire). restart with en=0 ignored.
//   - Outstanding: +1 per transfer, -1 per pixel_done; both same cycle -> unchanged.
//     pixel_done at count 0 ignored (no underflow). Saturates at 2^CNT_WIDTH-1.
//   - zoom/offset inputs changing mid-frame have no effect until next frame_start.
//   - Unsigned pixel counters; W,H need not be powers of two.
// TESTING
//   - W=4,H=3, full_queue=0, en=1: 12 pixels (0,0)..(3,2) on 12 consecutive cycles, then
//     pix_valid=0; pulse pixel_done 12x -> frame_done=1 one cycle after last pulse.
//   - full_queue=1 for 5 cycles at pixel (2,1): pixel_x=2,pixel_y=1,pix_valid=1 held;
//     release -> (3,1) then (0,2); no pixel lost or duplicated.
//   - Transfer and pixel_done same cycle with 3 outstanding -> count stays 3; pixel_done at
//     count 0 -> count stays 0, frame_done unaffected.
//   - restart at pixel (1,2) with zoom changed 2->4: next cycle pixel=(0,0), zoom_frame=4,
//     frame_start=1; frame_done only after all old+new pixels retired.
//   - en dropped at (3,0) for 4 cycles -> pix_valid=0, position held; en=1 -> (3,0) reissued
//     once, then (0,1).
//   - Assert reset mid-SCAN (async, between edges): outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/pixel_scan_gen.sv
// pixel_scan_gen
//   Raster-scan pixel source. Walks every (x,y) of a frame in row-major order,
//   latches the zoom/offset view once per frame, tracks how many issued
//   pixels are still being worked on by the engines and raises frame_done
//   once the whole frame has been issued and retired.
//
//   Handshake: a pixel moves downstream on a rising clk edge where
//   pix_valid=1 and full_queue=0 (full_queue is the inverted ready). While
//   full_queue=1 the presented pixel is held stable. Dropping en withdraws
//   pix_valid on the next cycle without advancing the position, so the
//   same pixel is presented again when en returns.

module pixel_scan_gen #(
   parameter int PIXEL_DATA_WIDTH  = 10,
   parameter int ENGINE_DATA_WIDTH = 25,
   parameter int SCREEN_WIDTH      = 640,
   parameter int SCREEN_HEIGHT     = 480,
   parameter int CNT_WIDTH         = 19
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         en,
   input  logic                         restart,
   input  logic                         full_queue,
   input  logic                         pixel_done,
   input  logic [2:0]                   zoom,
   input  logic [ENGINE_DATA_WIDTH-1:0] x_offset,
   input  logic [ENGINE_DATA_WIDTH-1:0] y_offset,
   output logic [PIXEL_DATA_WIDTH-1:0]  pixel_x,
   output logic [PIXEL_DATA_WIDTH-1:0]  pixel_y,
   output logic                         pix_valid,
   output logic [2:0]                   zoom_frame,
   output logic [ENGINE_DATA_WIDTH-1:0] x_off_frame,
   output logic [ENGINE_DATA_WIDTH-1:0] y_off_frame,
   output logic                         frame_start,
   output logic                         frame_done,
   output logic [1:0]                   state_dbg,
   output logic [CNT_WIDTH-1:0]         outstanding
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [PIXEL_DATA_WIDTH-1:0] X_LAST  = PIXEL_DATA_WIDTH'(SCREEN_WIDTH - 1);
   localparam logic [PIXEL_DATA_WIDTH-1:0] Y_LAST  = PIXEL_DATA_WIDTH'(SCREEN_HEIGHT - 1);
   localparam logic [CNT_WIDTH-1:0]        CNT_MAX = '1;

   state_t state;
   state_t state_nx;
   logic   transfer;
   logic   last_pixel;
   logic   start_frame;
   logic   cnt_zero;

   // A transfer is purely the handshake; it is counted even on a restart edge.
   assign transfer   = pix_valid & ~full_queue;
   assign last_pixel = (pixel_x == X_LAST) && (pixel_y == Y_LAST);
   assign cnt_zero   = (outstanding == '0);
   assign state_dbg  = state;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic; start_frame marks every edge that begins a new frame view.
   always_comb begin
      state_nx    = state;
      start_frame = 1'b0;
      case (state)
         ST_IDLE: begin
            if (en) begin
               start_frame = 1'b1;
               state_nx    = ST_SCAN;
            end
         end
         ST_SCAN: begin
            // restart takes priority over the move to DRAIN on the last pixel
            if (en && restart) begin
               start_frame = 1'b1;
               state_nx    = ST_SCAN;
            end else if (transfer && last_pixel) begin
               state_nx = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (en && restart) begin
               start_frame = 1'b1;
               state_nx    = ST_SCAN;
            end else if (cnt_zero) begin
               state_nx = ST_DONE;
            end
         end
         ST_DONE: begin
            if (en && restart) begin
               start_frame = 1'b1;
               state_nx    = ST_SCAN;
            end
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // Scan position: reset at frame start, advance row-major on each transfer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pixel_x <= '0;
         pixel_y <= '0;
      end else if (start_frame) begin
         pixel_x <= '0;
         pixel_y <= '0;
      end else if ((state == ST_SCAN) && transfer) begin
         if (last_pixel) begin
            pixel_x <= '0;
            pixel_y <= '0;
         end else if (pixel_x == X_LAST) begin
            pixel_x <= '0;
            pixel_y <= pixel_y + 1'b1;
         end else begin
            pixel_x <= pixel_x + 1'b1;
         end
      end
   end

   // pix_valid follows en while scanning and drops after the final pixel.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pix_valid <= 1'b0;
      end else if (start_frame) begin
         pix_valid <= 1'b1;
      end else if (state == ST_SCAN) begin
         if (transfer && last_pixel) begin
            pix_valid <= 1'b0;
         end else begin
            pix_valid <= en;
         end
      end else begin
         pix_valid <= 1'b0;
      end
   end

   // View latch: zoom/offsets are captured only when a frame starts.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         zoom_frame  <= '0;
         x_off_frame <= '0;
         y_off_frame <= '0;
      end else if (start_frame) begin
         zoom_frame  <= zoom;
         x_off_frame <= x_offset;
         y_off_frame <= y_offset;
      end
   end

   // One-cycle frame_start pulse aligned with the first pixel of the frame.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_start <= 1'b0;
      end else begin
         frame_start <= start_frame;
      end
   end

   // frame_done is a level that tracks residence in DONE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_done <= 1'b0;
      end else begin
         frame_done <= (state_nx == ST_DONE);
      end
   end

   // Outstanding pixels: +1 per transfer, -1 per retire, never wraps either way.
   // A restart does not clear it, so stale pixels of an abandoned frame are
   // still waited for before the next frame_done.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         outstanding <= '0;
      end else begin
         case ({transfer, pixel_done})
            2'b10: begin
               if (outstanding != CNT_MAX) begin
                  outstanding <= outstanding + 1'b1;
               end
            end
            2'b01: begin
               if (!cnt_zero) begin
                  outstanding <= outstanding - 1'b1;
               end
            end
            default: begin
               outstanding <= outstanding;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pixel_scan_gen.sv
// tb_pixel_scan_gen
//   Directed bench for pixel_scan_gen on a 4x3 screen. Expected pixels are
//   queued as each frame is started and checked in order as they transfer;
//   a small reference counter tracks outstanding pixels from the handshake.

module tb_pixel_scan_gen;

   localparam int PW = 10;
   localparam int EW = 25;
   localparam int W  = 4;
   localparam int H  = 3;
   localparam int CW = 8;

   localparam int S_IDLE  = 0;
   localparam int S_SCAN  = 1;
   localparam int S_DRAIN = 2;
   localparam int S_DONE  = 3;

   logic          clk;
   logic          rst;
   logic          en;
   logic          restart;
   logic          full_queue;
   logic          pixel_done;
   logic [2:0]    zoom;
   logic [EW-1:0] x_offset;
   logic [EW-1:0] y_offset;
   logic [PW-1:0] pixel_x;
   logic [PW-1:0] pixel_y;
   logic          pix_valid;
   logic [2:0]    zoom_frame;
   logic [EW-1:0] x_off_frame;
   logic [EW-1:0] y_off_frame;
   logic          frame_start;
   logic          frame_done;
   logic [1:0]    state_dbg;
   logic [CW-1:0] outstanding;

   logic [2*PW-1:0] exp_q[$];
   int              vectors;
   int              miscompares;
   int              model_cnt;
   int              used;

   pixel_scan_gen #(
      .PIXEL_DATA_WIDTH (PW),
      .ENGINE_DATA_WIDTH(EW),
      .SCREEN_WIDTH     (W),
      .SCREEN_HEIGHT    (H),
      .CNT_WIDTH        (CW)
   ) dut (
      .clk        (clk),
      .reset      (rst),
      .en         (en),
      .restart    (restart),
      .full_queue (full_queue),
      .pixel_done (pixel_done),
      .zoom       (zoom),
      .x_offset   (x_offset),
      .y_offset   (y_offset),
      .pixel_x    (pixel_x),
      .pixel_y    (pixel_y),
      .pix_valid  (pix_valid),
      .zoom_frame (zoom_frame),
      .x_off_frame(x_off_frame),
      .y_off_frame(y_off_frame),
      .frame_start(frame_start),
      .frame_done (frame_done),
      .state_dbg  (state_dbg),
      .outstanding(outstanding)
   );

   // clock / watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no end of test, expected finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_frame(input int n);
      for (int k = 0; k < n; k++) begin
         exp_q.push_back({PW'(k / W), PW'(k % W)});
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_pix(input string tag, input int x, input int y, input int v);
      check({tag, "_x"}, 32'(pixel_x), x);
      check({tag, "_y"}, 32'(pixel_y), y);
      check({tag, "_valid"}, 32'(pix_valid), v);
   endtask

   task automatic wait_frame_done(input int budget, output int cycles);
      cycles = 0;
      while (!frame_done && cycles < budget) begin
         tick(1);
         cycles++;
      end
      check("frame_done_rise", 32'(frame_done), 1);
   endtask

   // ---------------- scoreboard ----------------
   // Pops one expected pixel per transfer and keeps the reference count.
   always @(negedge clk) begin
      logic [2*PW-1:0] exp_pix;
      logic            xfer;
      if (!rst) begin
         xfer = pix_valid && !full_queue;
         if (xfer) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $error("FAIL pixel_unexpected: observed (%0d,%0d) expected none", pixel_x, pixel_y);
            end else begin
               exp_pix = exp_q.pop_front();
               check("pixel_order", 32'({pixel_y, pixel_x}), 32'(exp_pix));
            end
         end
         if (xfer && !pixel_done) begin
            model_cnt++;
         end else if (!xfer && pixel_done && model_cnt != 0) begin
            model_cnt--;
         end
      end
   end

   // ---------------- directed sequence ----------------
   initial begin
      vectors     = 0;
      miscompares = 0;
      model_cnt   = 0;
      rst         = 1'b1;
      en          = 1'b0;
      restart     = 1'b0;
      full_queue  = 1'b0;
      pixel_done  = 1'b0;
      zoom        = 3'd1;
      x_offset    = 25'h0ABCDE;
      y_offset    = 25'h1F0001;
      tick(2);

      // reset state
      check_pix("rst_pix", 0, 0, 0);
      check("rst_frame_start", 32'(frame_start), 0);
      check("rst_frame_done", 32'(frame_done), 0);
      check("rst_zoom_frame", 32'(zoom_frame), 0);
      check("rst_x_off_frame", 32'(x_off_frame), 0);
      check("rst_state", 32'(state_dbg), S_IDLE);
      check("rst_outstanding", 32'(outstanding), 0);
      rst = 1'b0;
      tick(1);
      check("idle_hold_state", 32'(state_dbg), S_IDLE);
      check("idle_hold_valid", 32'(pix_valid), 0);

      // frame 1: full 4x3 scan with no back-pressure
      push_frame(W * H);
      en = 1'b1;
      tick(1);
      check("f1_frame_start", 32'(frame_start), 1);
      check_pix("f1_first", 0, 0, 1);
      check("f1_zoom_frame", 32'(zoom_frame), 1);
      check("f1_x_off_frame", 32'(x_off_frame), 32'h0ABCDE);
      check("f1_y_off_frame", 32'(y_off_frame), 32'h1F0001);
      check("f1_state", 32'(state_dbg), S_SCAN);
      zoom     = 3'd5;
      x_offset = 25'h000077;
      tick(1);
      check("f1_frame_start_pulse", 32'(frame_start), 0);
      check("f1_zoom_midframe", 32'(zoom_frame), 1);
      check("f1_x_off_midframe", 32'(x_off_frame), 32'h0ABCDE);
      tick(W * H - 1);
      check("f1_end_valid", 32'(pix_valid), 0);
      check("f1_end_state", 32'(state_dbg), S_DRAIN);
      check("f1_all_issued", 32'(exp_q.size()), 0);
      check("f1_outstanding", 32'(outstanding), W * H);
      check("f1_outstanding_model", 32'(outstanding), 32'(model_cnt));
      pixel_done = 1'b1;
      tick(W * H);
      pixel_done = 1'b0;
      check("f1_retired", 32'(outstanding), 0);
      wait_frame_done(8, used);
      check("f1_done_latency", 32'(used), 1);
      check("f1_done_state", 32'(state_dbg), S_DONE);

      // retire at zero count is ignored
      pixel_done = 1'b1;
      tick(1);
      pixel_done = 1'b0;
      tick(1);
      check("zero_retire_cnt", 32'(outstanding), 0);
      check("zero_retire_done", 32'(frame_done), 1);
      check("zero_retire_valid", 32'(pix_valid), 0);

      // frame 2: restart from DONE, back-pressure at (2,1)
      zoom     = 3'd2;
      x_offset = 25'h1000003;
      push_frame(10);
      restart = 1'b1;
      tick(1);
      restart = 1'b0;
      check("f2_frame_start", 32'(frame_start), 1);
      check("f2_frame_done_clr", 32'(frame_done), 0);
      check("f2_zoom_frame", 32'(zoom_frame), 2);
      check("f2_x_off_frame", 32'(x_off_frame), 32'h1000003);
      check_pix("f2_first", 0, 0, 1);
      tick(6);
      check_pix("f2_at_2_1", 2, 1, 1);
      full_queue = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i == 2) zoom = 3'd6;
         tick(1);
         check_pix("f2_hold", 2, 1, 1);
      end
      check("f2_zoom_unchanged", 32'(zoom_frame), 2);
      full_queue = 1'b0;
      tick(1);
      check_pix("f2_after_hold", 3, 1, 1);
      tick(1);
      check_pix("f2_wrap", 0, 2, 1);
      tick(1);
      check_pix("f2_at_1_2", 1, 2, 1);

      // frame 3: restart mid-scan with a same-cycle transfer of (1,2)
      zoom = 3'd4;
      push_frame(W * H);
      restart = 1'b1;
      tick(1);
      restart = 1'b0;
      check_pix("f3_first", 0, 0, 1);
      check("f3_zoom_frame", 32'(zoom_frame), 4);
      check("f3_frame_start", 32'(frame_start), 1);
      check("f3_frame_done", 32'(frame_done), 0);
      check("f3_state", 32'(state_dbg), S_SCAN);
      check("f3_stale_outstanding", 32'(outstanding), 10);

      // en dropped while (3,0) becomes current
      tick(2);
      check_pix("f3_at_2_0", 2, 0, 1);
      en = 1'b0;
      tick(1);
      check_pix("f3_pause", 3, 0, 0);
      for (int i = 0; i < 3; i++) begin
         tick(1);
         check_pix("f3_pause_hold", 3, 0, 0);
      end
      en = 1'b1;
      tick(1);
      check_pix("f3_resume", 3, 0, 1);
      tick(1);
      check_pix("f3_next_row", 0, 1, 1);
      tick(8);
      check("f3_end_valid", 32'(pix_valid), 0);
      check("f3_end_state", 32'(state_dbg), S_DRAIN);
      check("f3_all_issued", 32'(exp_q.size()), 0);
      check("f3_outstanding", 32'(outstanding), 22);
      check("f3_outstanding_model", 32'(outstanding), 32'(model_cnt));
      pixel_done = 1'b1;
      tick(21);
      pixel_done = 1'b0;
      tick(2);
      check("f3_one_left_cnt", 32'(outstanding), 1);
      check("f3_one_left_done", 32'(frame_done), 0);
      check("f3_one_left_state", 32'(state_dbg), S_DRAIN);
      pixel_done = 1'b1;
      tick(1);
      pixel_done = 1'b0;
      wait_frame_done(8, used);
      check("f3_done_latency", 32'(used), 1);
      check("f3_retired", 32'(outstanding), 0);

      // frame 4: simultaneous transfer and retire at count 3
      zoom = 3'd7;
      push_frame(W * H);
      restart = 1'b1;
      tick(1);
      restart = 1'b0;
      check("f4_zoom_frame", 32'(zoom_frame), 7);
      check("f4_frame_start", 32'(frame_start), 1);
      tick(3);
      check("f4_cnt3", 32'(outstanding), 3);
      full_queue = 1'b1;
      tick(1);
      check("f4_cnt3_held", 32'(outstanding), 3);
      check_pix("f4_held", 3, 0, 1);
      full_queue = 1'b0;
      pixel_done = 1'b1;
      tick(1);
      pixel_done = 1'b0;
      check("f4_xfer_and_retire", 32'(outstanding), 3);
      check("f4_cnt_model", 32'(outstanding), 32'(model_cnt));
      check_pix("f4_advanced", 0, 1, 1);
      tick(1);

      // asynchronous reset between clock edges, mid-scan
      #2;
      rst = 1'b1;
      #1;
      check_pix("arst_pix", 0, 0, 0);
      check("arst_state", 32'(state_dbg), S_IDLE);
      check("arst_outstanding", 32'(outstanding), 0);
      check("arst_zoom_frame", 32'(zoom_frame), 0);
      check("arst_frame_done", 32'(frame_done), 0);
      check("arst_frame_start", 32'(frame_start), 0);
      exp_q.delete();
      model_cnt = 0;
      en        = 1'b0;
      tick(1);
      rst = 1'b0;
      tick(3);
      check("post_rst_state", 32'(state_dbg), S_IDLE);
      check("post_rst_valid", 32'(pix_valid), 0);
      check("final_queue_empty", 32'(exp_q.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
